// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter that drives a registered register-file write port.
// Optional post-reset clear sweep of registers 1..NUM_REG-1 is enabled with REGFILE_WB_INIT_CLEAR_EN.
module regfile_wb_arbiter #(
    parameter  int NUM_REG = 32,
    parameter  int WIDTH   = 32,
    localparam int AW      = $clog2(NUM_REG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rf_we,
    output logic [AW-1:0]    rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             init_busy
);

    logic             r_we;
    logic [AW-1:0]    r_wa;
    logic [WIDTH-1:0] r_wd;
    logic             r_ptr;
    logic             w_run;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_both;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;

`ifdef REGFILE_WB_INIT_CLEAR_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REG - 1);
    state_t        r_state;
    logic [AW-1:0] r_cnt;

    assign w_run     = (r_state == ST_RUN) & ~reset;
    assign init_busy = (r_state == ST_INIT);
`else
    assign w_run     = ~reset;
    assign init_busy = 1'b0;
`endif

    // r_ptr=0 favours requester 0 on contention
    assign w_both     = w_run & req0_valid & req1_valid;
    assign w_gnt0     = w_run & req0_valid & (~req1_valid | ~r_ptr);
    assign w_gnt1     = w_run & req1_valid & (~req0_valid | r_ptr);
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_addr     = w_gnt1 ? req1_addr : req0_addr;
    assign w_data     = w_gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_wa    <= '0;
            r_wd    <= '0;
            r_ptr   <= 1'b0;
`ifdef REGFILE_WB_INIT_CLEAR_EN
            r_state <= ST_INIT;
            r_cnt   <= AW'(1);
`endif
        end else begin
`ifdef REGFILE_WB_INIT_CLEAR_EN
            if (r_state == ST_INIT) begin
                r_we <= 1'b1;
                r_wa <= r_cnt;
                r_wd <= '0;
                if (r_cnt == LAST_ADDR) r_state <= ST_RUN;
                else                    r_cnt   <= r_cnt + AW'(1);
            end else
`endif
            begin
                // address 0 is hardwired: handshake completes but no write issues
                r_we <= (w_gnt0 | w_gnt1) & (w_addr != '0);
                if ((w_gnt0 | w_gnt1) && (w_addr != '0)) begin
                    r_wa <= w_addr;
                    r_wd <= w_data;
                end
                if (w_both) r_ptr <= ~r_ptr;
            end
        end
    end

    assign rf_we = r_we;
    assign rf_wa = r_wa;
    assign rf_wd = r_wd;

endmodule
